// File: rtl/seq_core_regfile_fwd.sv
// Register file for the READ stage with EX/WB operand bypass and load-use scoreboard.
// Latency: operands and stall are combinational from current inputs and state; writes land at the rising edge.
// Backpressure: stall holds PC/IR/R1 upstream; a saturating counter tallies stall cycles.
module seq_core_regfile_fwd #(
    parameter int D_SIZE   = 32,
    parameter int R_COUNT  = 8,
    parameter int CNT_SIZE = 16,
    localparam int R_ADDR  = $clog2(R_COUNT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [R_ADDR-1:0]   src1,
    input  logic [R_ADDR-1:0]   src2,
    input  logic                src1_used,
    input  logic                src2_used,
    output logic [D_SIZE-1:0]   operand_1,
    output logic [D_SIZE-1:0]   operand_2,
    input  logic                ex_write_en,
    input  logic                ex_is_load,
    input  logic [R_ADDR-1:0]   ex_dest,
    input  logic [D_SIZE-1:0]   ex_result,
    input  logic                ex_flush,
    input  logic                wb_write_en,
    input  logic                wb_is_load,
    input  logic [R_ADDR-1:0]   wb_dest,
    input  logic [D_SIZE-1:0]   wb_data,
    output logic                stall,
    output logic [CNT_SIZE-1:0] stall_count
);

    localparam logic [CNT_SIZE-1:0] CNT_MAX = {CNT_SIZE{1'b1}};
    localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);

    logic [D_SIZE-1:0]  regs [R_COUNT];
    logic [R_COUNT-1:0] pending;
    logic [R_COUNT-1:0] pending_nxt;
    logic [CNT_SIZE-1:0] cnt;

    // An EX load whose data is not known yet; an EX ALU result that can be bypassed;
    // a load returning through WB this cycle.
    logic ex_load_live;
    logic ex_alu_fwd;
    logic wb_load_ret;
    logic hazard_1;
    logic hazard_2;
    logic [D_SIZE-1:0] sel_1;
    logic [D_SIZE-1:0] sel_2;

    assign ex_load_live = ex_write_en &  ex_is_load & ~ex_flush;
    assign ex_alu_fwd   = ex_write_en & ~ex_is_load & ~ex_flush;
    assign wb_load_ret  = wb_write_en &  wb_is_load;

    // Operand 1 select: EX bypass, then WB bypass, then the array.
    always_comb begin
        sel_1 = regs[src1];
        if (ex_alu_fwd && ex_dest == src1) begin
            sel_1 = ex_result;
        end else if (wb_write_en && wb_dest == src1) begin
            sel_1 = wb_data;
        end
    end

    // Operand 2 select: same priority as operand 1.
    always_comb begin
        sel_2 = regs[src2];
        if (ex_alu_fwd && ex_dest == src2) begin
            sel_2 = ex_result;
        end else if (wb_write_en && wb_dest == src2) begin
            sel_2 = wb_data;
        end
    end

    // A used source waits for a load still in EX, or for an outstanding load not returning now.
    always_comb begin
        hazard_1 = src1_used &
                   ((ex_load_live & (ex_dest == src1)) |
                    (pending[src1] & ~(wb_load_ret & (wb_dest == src1))));
        hazard_2 = src2_used &
                   ((ex_load_live & (ex_dest == src2)) |
                    (pending[src2] & ~(wb_load_ret & (wb_dest == src2))));
    end

    // Outputs are forced quiet while reset is held.
    always_comb begin
        stall     = ~rst & (hazard_1 | hazard_2);
        operand_1 = rst ? '0 : sel_1;
        operand_2 = rst ? '0 : sel_2;
    end

    // Scoreboard next state: clear on load return first so a newer load to the same index wins.
    always_comb begin
        pending_nxt = pending;
        if (wb_load_ret) begin
            pending_nxt[wb_dest] = 1'b0;
        end
        if (ex_load_live && !stall) begin
            pending_nxt[ex_dest] = 1'b1;
        end
    end

    // Register array write from WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < R_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write_en) begin
            regs[wb_dest] <= wb_data;
        end
    end

    // Scoreboard register; reset forgets in-flight loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (stall && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign stall_count = cnt;

endmodule

// File: tb/tb_seq_core_regfile_fwd.sv
// Scoreboard bench for seq_core_regfile_fwd: directed scenarios plus random traffic.
// Driver pushes expected outputs from a behavioural model; monitor checks on the falling edge.
// Small stall counter width so saturation is reachable.
module tb_seq_core_regfile_fwd;

    localparam int D  = 32;
    localparam int RC = 8;
    localparam int RA = 3;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [RA-1:0] src1, src2;
    logic          src1_used, src2_used;
    logic [D-1:0]  operand_1, operand_2;
    logic          ex_write_en, ex_is_load, ex_flush;
    logic [RA-1:0] ex_dest;
    logic [D-1:0]  ex_result;
    logic          wb_write_en, wb_is_load;
    logic [RA-1:0] wb_dest;
    logic [D-1:0]  wb_data;
    logic          stall;
    logic [CW-1:0] stall_count;

    seq_core_regfile_fwd #(.D_SIZE(D), .R_COUNT(RC), .CNT_SIZE(CW)) dut (
        .clk(clk), .rst(rst),
        .src1(src1), .src2(src2), .src1_used(src1_used), .src2_used(src2_used),
        .operand_1(operand_1), .operand_2(operand_2),
        .ex_write_en(ex_write_en), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
        .ex_result(ex_result), .ex_flush(ex_flush),
        .wb_write_en(wb_write_en), .wb_is_load(wb_is_load), .wb_dest(wb_dest),
        .wb_data(wb_data),
        .stall(stall), .stall_count(stall_count)
    );

    typedef struct {
        logic [RA-1:0] s1, s2;
        bit            u1, u2;
        bit            ex_we, ex_ld, flush;
        logic [RA-1:0] ex_d;
        logic [D-1:0]  ex_r;
        bit            wb_we, wb_ld;
        logic [RA-1:0] wb_d;
        logic [D-1:0]  wb_v;
    } stim_t;

    typedef struct {
        logic [D-1:0]  op1, op2;
        bit            stl;
        int            cnt;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    logic [D-1:0] m_regs [RC];
    bit           m_pend [RC];
    int           m_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t idle();
        stim_t s;
        s.s1 = '0; s.s2 = '0; s.u1 = 0; s.u2 = 0;
        s.ex_we = 0; s.ex_ld = 0; s.flush = 0; s.ex_d = '0; s.ex_r = '0;
        s.wb_we = 0; s.wb_ld = 0; s.wb_d = '0; s.wb_v = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.s1 = RA'($urandom_range(0, RC-1));
        s.s2 = RA'($urandom_range(0, RC-1));
        s.u1 = ($urandom_range(0, 3) != 0);
        s.u2 = ($urandom_range(0, 3) != 0);
        s.ex_we = $urandom_range(0, 1);
        s.ex_ld = ($urandom_range(0, 2) == 0);
        s.flush = ($urandom_range(0, 5) == 0);
        s.ex_d = RA'($urandom_range(0, RC-1));
        s.ex_r = $urandom;
        s.wb_we = $urandom_range(0, 1);
        s.wb_ld = $urandom_range(0, 1);
        s.wb_d = RA'($urandom_range(0, RC-1));
        s.wb_v = $urandom;
        return s;
    endfunction

    function automatic logic [D-1:0] model_read(stim_t s, logic [RA-1:0] src);
        if (s.ex_we && !s.ex_ld && !s.flush && s.ex_d == src) return s.ex_r;
        if (s.wb_we && s.wb_d == src) return s.wb_v;
        return m_regs[src];
    endfunction

    function automatic bit model_wait(stim_t s, bit used, logic [RA-1:0] src);
        bit load_in_ex, outstanding;
        load_in_ex  = s.ex_we && s.ex_ld && !s.flush && s.ex_d == src;
        outstanding = m_pend[src] && !(s.wb_we && s.wb_ld && s.wb_d == src);
        return used && (load_in_ex || outstanding);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < RC; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
        m_cnt = 0;
    endtask

    // Issue one cycle of stimulus, record what the DUT must show, then advance the model.
    task automatic drive(input stim_t s, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        src1 = s.s1; src2 = s.s2; src1_used = s.u1; src2_used = s.u2;
        ex_write_en = s.ex_we; ex_is_load = s.ex_ld; ex_flush = s.flush;
        ex_dest = s.ex_d; ex_result = s.ex_r;
        wb_write_en = s.wb_we; wb_is_load = s.wb_ld; wb_dest = s.wb_d; wb_data = s.wb_v;
        e.op1 = model_read(s, s.s1);
        e.op2 = model_read(s, s.s2);
        e.stl = model_wait(s, s.u1, s.s1) || model_wait(s, s.u2, s.s2);
        e.cnt = m_cnt;
        e.tag = tag;
        exp_q.push_back(e);
        if (e.stl && m_cnt < (1 << CW) - 1) m_cnt++;
        if (s.wb_we) m_regs[s.wb_d] = s.wb_v;
        if (s.wb_we && s.wb_ld) m_pend[s.wb_d] = 0;
        if (s.ex_we && s.ex_ld && !s.flush && !e.stl) m_pend[s.ex_d] = 1;
    endtask

    // Assert reset mid-cycle with whatever inputs are currently applied.
    task automatic do_reset(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        e.op1 = '0; e.op2 = '0; e.stl = 0; e.cnt = 0; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented output against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 4;
            if (operand_1 !== e.op1) begin
                errors++;
                $display("FAIL %s operand_1: got %h expected %h", e.tag, operand_1, e.op1);
            end
            if (operand_2 !== e.op2) begin
                errors++;
                $display("FAIL %s operand_2: got %h expected %h", e.tag, operand_2, e.op2);
            end
            if (stall !== e.stl) begin
                errors++;
                $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.stl);
            end
            if (stall_count !== CW'(e.cnt)) begin
                errors++;
                $display("FAIL %s stall_count: got %0d expected %0d", e.tag, stall_count, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        src1 = '0; src2 = '0; src1_used = 0; src2_used = 0;
        ex_write_en = 0; ex_is_load = 0; ex_flush = 0; ex_dest = '0; ex_result = '0;
        wb_write_en = 0; wb_is_load = 0; wb_dest = '0; wb_data = '0;
        model_clear();

        do_reset("reset");
        for (int i = 0; i < RC; i++) begin
            s = idle(); s.s1 = RA'(i); s.s2 = RA'(RC-1-i); s.u1 = 1; s.u2 = 1;
            drive(s, "read_after_reset");
        end

        // WB write visible by bypass the same cycle and from the array afterwards
        s = idle(); s.wb_we = 1; s.wb_d = 3; s.wb_v = 32'hDEADBEEF; s.s1 = 3; s.u1 = 1;
        drive(s, "wb_bypass");
        s = idle(); s.s1 = 3; s.u1 = 1;
        drive(s, "wb_array");

        // EX result beats WB to the same register
        s = idle(); s.ex_we = 1; s.ex_d = 5; s.ex_r = 32'h12;
        s.wb_we = 1; s.wb_d = 5; s.wb_v = 32'h34; s.s2 = 5; s.u2 = 1;
        drive(s, "ex_priority");

        // Load-use distance 1
        do_reset("reset2");
        s = idle(); s.ex_we = 1; s.ex_ld = 1; s.ex_d = 2; s.s1 = 2; s.u1 = 1;
        drive(s, "load_use_stall");
        s = idle(); s.wb_we = 1; s.wb_ld = 1; s.wb_d = 2; s.wb_v = 32'h55; s.s1 = 2; s.u1 = 1;
        drive(s, "load_return");
        s = idle(); s.s1 = 2; s.u1 = 1;
        drive(s, "load_after");

        // Slow load: pending bit holds the consumer for three cycles
        s = idle(); s.ex_we = 1; s.ex_ld = 1; s.ex_d = 4; s.s1 = 1; s.u1 = 1;
        drive(s, "slow_load_issue");
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.s1 = 4; s.u1 = 1;
            drive(s, "slow_load_wait");
        end
        s = idle(); s.wb_we = 1; s.wb_ld = 1; s.wb_d = 4; s.wb_v = 32'hA5A5; s.s1 = 4; s.u1 = 1;
        drive(s, "slow_load_release");

        // Flushed load never stalls and leaves nothing pending
        s = idle(); s.ex_we = 1; s.ex_ld = 1; s.flush = 1; s.ex_d = 4; s.s1 = 4; s.u1 = 1;
        drive(s, "flush_load");
        s = idle(); s.s1 = 4; s.u1 = 1;
        drive(s, "flush_after");

        // Unused source never stalls
        s = idle(); s.ex_we = 1; s.ex_ld = 1; s.ex_d = 4; s.s1 = 4; s.u1 = 0;
        drive(s, "unused_src");
        s = idle(); s.s2 = 4; s.u2 = 0;
        drive(s, "unused_pending");
        s = idle(); s.wb_we = 1; s.wb_ld = 1; s.wb_d = 4; s.wb_v = 32'h77;
        drive(s, "unused_clear");

        // Saturation of the stall counter
        for (int i = 0; i < (1 << CW) + 5; i++) begin
            s = idle(); s.ex_we = 1; s.ex_ld = 1; s.ex_d = 1; s.s2 = 1; s.u2 = 1;
            drive(s, "saturate");
        end
        drive(idle(), "saturate_hold");

        // Reset while stalling
        s = idle(); s.ex_we = 1; s.ex_ld = 1; s.ex_d = 6; s.s1 = 6; s.u1 = 1;
        drive(s, "pre_reset_stall");
        do_reset("reset_mid_stall");
        drive(idle(), "post_reset");

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rand_reset");
            else drive(rand_stim(), "random");
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
